// File: rtl/anc_pkg.sv
// Shared definitions for the ANC FIR multiply-accumulate block.
// Contents: default width constants, ceil-log2 helper, filter state enum.
package anc_pkg;

   localparam int unsigned DefDataW = 11;
   localparam int unsigned DefCoefW = 11;
   localparam int unsigned DefTaps  = 16;
   localparam int unsigned DefShift = 10;

   // Ceil(log2(v)), never less than 1 so index ports always have a bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) begin
         r++;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StRound
   } filt_state_e;

endpackage

// File: rtl/anc_fir_mac_if.sv
// Sample/coefficient/result bundle for anc_fir_mac.
// master: drives Sample_Valid_In, Sig_In, Coef_Wr_En, Coef_Wr_Addr, Wz_In, Coef_Commit;
//         receives Busy, FiltOut, Out_Valid, Overflow, Drop.
// slave : the filter side, directions reversed.
interface anc_fir_mac_if
   import anc_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned COEF_W = DefCoefW,
   parameter int unsigned TAPS   = DefTaps
);
   localparam int unsigned AW = clog2(TAPS);

   logic                     Sample_Valid_In;
   logic signed [DATA_W-1:0] Sig_In;
   logic                     Coef_Wr_En;
   logic [AW-1:0]            Coef_Wr_Addr;
   logic signed [COEF_W-1:0] Wz_In;
   logic                     Coef_Commit;
   logic                     Busy;
   logic signed [DATA_W-1:0] FiltOut;
   logic                     Out_Valid;
   logic                     Overflow;
   logic                     Drop;

   modport master (
      output Sample_Valid_In, Sig_In, Coef_Wr_En, Coef_Wr_Addr, Wz_In, Coef_Commit,
      input  Busy, FiltOut, Out_Valid, Overflow, Drop
   );

   modport slave (
      input  Sample_Valid_In, Sig_In, Coef_Wr_En, Coef_Wr_Addr, Wz_In, Coef_Commit,
      output Busy, FiltOut, Out_Valid, Overflow, Drop
   );

endinterface

// File: rtl/anc_round_sat.sv
// Combinational round-half-up by 2^SHIFT followed by saturation to DATA_W.
// Ports: acc_i  - full-precision signed accumulator
//        res_o  - rounded, saturated result
//        clip_o - high when saturation changed the rounded value
module anc_round_sat
   import anc_pkg::*;
#(
   parameter int unsigned ACC_W  = DefDataW + DefCoefW + clog2(DefTaps),
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned SHIFT  = DefShift
) (
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [DATA_W-1:0] res_o,
   output logic                     clip_o
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam logic signed [ACC_W:0] Half   = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] MaxVal = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MinVal = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shr;

   always_comb begin
      sum    = $signed({acc_i[ACC_W-1], acc_i}) + Half;
      shr    = sum >>> SHIFT;
      clip_o = 1'b0;
      res_o  = shr[DATA_W-1:0];
      if (shr > MaxVal) begin
         res_o  = {1'b0, {(DATA_W-1){1'b1}}};
         clip_o = 1'b1;
      end else if (shr < MinVal) begin
         res_o  = {1'b1, {(DATA_W-1){1'b0}}};
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/anc_fir_mac.sv
// Serial FIR filter for ANC: one tap per clock into a full-precision accumulator,
// then a rounding/saturation cycle. Coefficients are double-buffered (shadow/active).
// Ports: Clk_100M - clock, rising edge
//        Reset    - synchronous active-high reset
//        fir_if   - slave side of anc_fir_mac_if (sample in, coefficient writes,
//                   Busy/FiltOut/Out_Valid/Overflow/Drop out)
module anc_fir_mac
   import anc_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned COEF_W = DefCoefW,
   parameter int unsigned TAPS   = DefTaps,
   parameter int unsigned SHIFT  = DefShift
) (
   input logic          Clk_100M,
   input logic          Reset,
   anc_fir_mac_if.slave fir_if
);

   localparam int unsigned AW     = clog2(TAPS);
   localparam int unsigned ACC_W  = DATA_W + COEF_W + AW;
   localparam int unsigned PROD_W = DATA_W + COEF_W;

   filt_state_e              state_q, state_d;
   logic [AW-1:0]            tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [DATA_W-1:0] x_d [TAPS];
   logic signed [COEF_W-1:0] w_sh_q [TAPS];
   logic signed [COEF_W-1:0] w_sh_d [TAPS];
   logic signed [COEF_W-1:0] w_act_q [TAPS];
   logic signed [COEF_W-1:0] w_act_d [TAPS];
   logic                     pend_q, pend_d;
   logic signed [DATA_W-1:0] filt_q, filt_d;
   logic                     out_valid_q, out_valid_d;
   logic                     ovf_q, ovf_d;
   logic                     drop_q, drop_d;

   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] rs_res;
   logic                     rs_clip;
   logic                     copy;

   anc_round_sat #(
      .ACC_W (ACC_W),
      .DATA_W(DATA_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .acc_i (acc_q),
      .res_o (rs_res),
      .clip_o(rs_clip)
   );

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      acc_d       = acc_q;
      x_d         = x_q;
      w_sh_d      = w_sh_q;
      w_act_d     = w_act_q;
      pend_d      = pend_q | fir_if.Coef_Commit;
      filt_d      = filt_q;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
      drop_d      = 1'b0;

      prod = PROD_W'(x_q[tap_q]) * PROD_W'(w_act_q[tap_q]);

      if (fir_if.Coef_Wr_En) begin
         w_sh_d[fir_if.Coef_Wr_Addr] = fir_if.Wz_In;
      end

      // Copy from the post-write shadow so a same-cycle write is included; only
      // in IDLE so the active bank is stable for a whole MAC pass.
      copy = (state_q == StIdle) && (pend_q || fir_if.Coef_Commit);
      if (copy) begin
         w_act_d = w_sh_d;
         pend_d  = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (fir_if.Sample_Valid_In) begin
               state_d = StMac;
               tap_d   = '0;
               acc_d   = '0;
               x_d[0]  = fir_if.Sig_In;
               for (int k = 1; k < TAPS; k++) begin
                  x_d[k] = x_q[k-1];
               end
            end
         end
         StMac: begin
            acc_d  = acc_q + ACC_W'(prod);
            tap_d  = tap_q + AW'(1);
            drop_d = fir_if.Sample_Valid_In;
            if (tap_q == AW'(TAPS - 1)) begin
               state_d = StRound;
            end
         end
         StRound: begin
            state_d     = StIdle;
            filt_d      = rs_res;
            out_valid_d = 1'b1;
            ovf_d       = rs_clip;
            drop_d      = fir_if.Sample_Valid_In;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk_100M) begin
      if (Reset) begin
         state_q     <= StIdle;
         tap_q       <= '0;
         acc_q       <= '0;
         pend_q      <= 1'b0;
         filt_q      <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k]     <= '0;
            w_sh_q[k]  <= '0;
            w_act_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         acc_q       <= acc_d;
         pend_q      <= pend_d;
         filt_q      <= filt_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
         x_q         <= x_d;
         w_sh_q      <= w_sh_d;
         w_act_q     <= w_act_d;
      end
   end

   assign fir_if.Busy      = (state_q != StIdle);
   assign fir_if.FiltOut   = filt_q;
   assign fir_if.Out_Valid = out_valid_q;
   assign fir_if.Overflow  = ovf_q;
   assign fir_if.Drop      = drop_q;

endmodule

// File: tb/tb_anc_fir_mac.sv
// Directed bench for anc_fir_mac with TAPS=4, SHIFT=10, DATA_W=11.
// Coefficient width is 13 so that the weights 1024 and 2048 are representable.
module tb_anc_fir_mac;

   localparam int unsigned DW = 11;
   localparam int unsigned CW = 13;
   localparam int unsigned TP = 4;
   localparam int unsigned SH = 10;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   ov_cnt = 0;
   int   drop_cnt = 0;
   int   lat, res, ov;
   int   ov_base, drop_base;

   anc_fir_mac_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(TP)) bus ();

   anc_fir_mac #(
      .DATA_W(DW),
      .COEF_W(CW),
      .TAPS  (TP),
      .SHIFT (SH)
   ) dut (
      .Clk_100M(clk),
      .Reset   (rst),
      .fir_if  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.Out_Valid) ov_cnt++;
      if (bus.Drop) drop_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wr_coef(input int addr, input int val, input bit commit);
      bus.Coef_Wr_En   = 1'b1;
      bus.Coef_Wr_Addr = addr[1:0];
      bus.Wz_In        = val[CW-1:0];
      bus.Coef_Commit  = commit;
      tick();
      bus.Coef_Wr_En   = 1'b0;
      bus.Coef_Commit  = 1'b0;
   endtask

   // Advance until Out_Valid is seen; cyc counts cycles since the strobe.
   task automatic wait_out(input int cyc, output int l, output int r, output int o);
      l = -1;
      r = 0;
      o = 0;
      for (int n = 0; n < 30; n++) begin
         if (bus.Out_Valid) begin
            l = cyc;
            r = int'($signed(bus.FiltOut));
            o = int'(bus.Overflow);
            break;
         end
         tick();
         cyc++;
      end
   endtask

   task automatic run_sample(input int s, output int l, output int r, output int o);
      bus.Sample_Valid_In = 1'b1;
      bus.Sig_In          = s[DW-1:0];
      tick();
      bus.Sample_Valid_In = 1'b0;
      wait_out(1, l, r, o);
   endtask

   initial begin
      rst                 = 1'b1;
      bus.Sample_Valid_In = 1'b0;
      bus.Sig_In          = '0;
      bus.Coef_Wr_En      = 1'b0;
      bus.Coef_Wr_Addr    = '0;
      bus.Wz_In           = '0;
      bus.Coef_Commit     = 1'b0;
      apply_reset();

      chk("rst_busy", int'(bus.Busy), 0);
      chk("rst_filtout", int'($signed(bus.FiltOut)), 0);
      chk("rst_out_valid", int'(bus.Out_Valid), 0);
      chk("rst_overflow", int'(bus.Overflow), 0);
      chk("rst_drop", int'(bus.Drop), 0);

      // Identity: w0 = 1.0 in Q10
      wr_coef(0, 1024, 1'b1);
      run_sample(300, lat, res, ov);
      chk("ident_latency", lat, 6);
      chk("ident_value", res, 300);
      chk("ident_overflow", ov, 0);

      // Rounding: w0 = 0.5; 1.5 -> 2, -1.5 -> -1
      wr_coef(0, 512, 1'b1);
      run_sample(3, lat, res, ov);
      chk("round_pos", res, 2);
      run_sample(-3, lat, res, ov);
      chk("round_neg", res, -1);

      // Saturation, commit issued together with the last write
      apply_reset();
      wr_coef(0, 1023, 1'b0);
      wr_coef(1, 1023, 1'b0);
      wr_coef(2, 1023, 1'b0);
      wr_coef(3, 1023, 1'b1);
      run_sample(1023, lat, res, ov);
      chk("sat_first_value", res, 1022);
      chk("sat_first_overflow", ov, 0);
      run_sample(1023, lat, res, ov);
      run_sample(1023, lat, res, ov);
      run_sample(1023, lat, res, ov);
      chk("sat_pos_value", res, 1023);
      chk("sat_pos_overflow", ov, 1);
      run_sample(-1024, lat, res, ov);
      run_sample(-1024, lat, res, ov);
      run_sample(-1024, lat, res, ov);
      run_sample(-1024, lat, res, ov);
      chk("sat_neg_value", res, -1024);
      chk("sat_neg_overflow", ov, 1);

      // Busy drop: second strobe two cycles after the first
      apply_reset();
      wr_coef(0, 1024, 1'b1);
      ov_base   = ov_cnt;
      drop_base = drop_cnt;
      bus.Sample_Valid_In = 1'b1;
      bus.Sig_In          = 11'sd100;
      tick();
      bus.Sample_Valid_In = 1'b0;
      tick();
      bus.Sample_Valid_In = 1'b1;
      bus.Sig_In          = 11'sd200;
      chk("drop_busy", int'(bus.Busy), 1);
      tick();
      bus.Sample_Valid_In = 1'b0;
      chk("drop_pulse", int'(bus.Drop), 1);
      wait_out(3, lat, res, ov);
      chk("drop_latency", lat, 6);
      chk("drop_value", res, 100);
      for (int n = 0; n < 6; n++) tick();
      chk("drop_out_valid_count", ov_cnt - ov_base, 1);
      chk("drop_pulse_count", drop_cnt - drop_base, 1);
      // Tap 1 must hold 100, not the rejected 200
      wr_coef(0, 0, 1'b0);
      wr_coef(1, 1024, 1'b1);
      run_sample(50, lat, res, ov);
      chk("drop_delay_line", res, 100);

      // Shadow commit mid-MAC
      apply_reset();
      wr_coef(0, 1024, 1'b1);
      bus.Sample_Valid_In = 1'b1;
      bus.Sig_In          = 11'sd10;
      tick();
      bus.Sample_Valid_In = 1'b0;
      tick();
      bus.Coef_Wr_En      = 1'b1;
      bus.Coef_Wr_Addr    = 2'd0;
      bus.Wz_In           = 13'sd2048;
      bus.Coef_Commit     = 1'b1;
      tick();
      bus.Coef_Wr_En      = 1'b0;
      bus.Coef_Commit     = 1'b0;
      wait_out(3, lat, res, ov);
      chk("shadow_old_coef", res, 10);
      run_sample(10, lat, res, ov);
      chk("shadow_new_coef", res, 20);

      // Reset mid-MAC at cycle 3
      bus.Sample_Valid_In = 1'b1;
      bus.Sig_In          = 11'sd77;
      tick();
      bus.Sample_Valid_In = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", int'(bus.Busy), 0);
      chk("mid_rst_filtout", int'($signed(bus.FiltOut)), 0);
      chk("mid_rst_out_valid", int'(bus.Out_Valid), 0);
      chk("mid_rst_overflow", int'(bus.Overflow), 0);
      chk("mid_rst_drop", int'(bus.Drop), 0);
      ov_base = ov_cnt;
      for (int n = 0; n < 10; n++) tick();
      chk("mid_rst_no_out_valid", ov_cnt - ov_base, 0);
      run_sample(55, lat, res, ov);
      chk("mid_rst_zero_coef_latency", lat, 6);
      chk("mid_rst_zero_coef", res, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
